// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative multiply/divide unit.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package muldiv_unit_pkg;

  localparam int kMULDIV_W = 32;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,  // low half of product
    OP_MULHU = 2'b01,  // high half of product
    OP_DIVU  = 2'b10,  // quotient
    OP_REMU  = 2'b11   // remainder
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
// Ports: op selects mul/div path; p is the 2W product register, r the W+1
// remainder, q the quotient, b the multiplier/divisor; *_nxt are the
// post-iteration values (the unused path passes through unchanged).
module muldiv_step
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = kMULDIV_W
) (
  input  muldiv_op_e         op,
  input  logic [2*WIDTH-1:0] p,
  input  logic [WIDTH:0]     r,
  input  logic [WIDTH-1:0]   q,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p_nxt,
  output logic [WIDTH:0]     r_nxt,
  output logic [WIDTH-1:0]   q_nxt
);

  logic [WIDTH:0]   mul_sum;  // carry out lands in the top bit
  logic [WIDTH+1:0] rq_sh;    // remainder shifted left, next dividend bit in
  logic             sub_ok;   // trial subtraction would stay non-negative

  assign mul_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, b} : '0);
  assign rq_sh   = {r, q[WIDTH-1]};
  assign sub_ok  = (rq_sh >= {2'b00, b});

  always_comb begin
    p_nxt = p;
    r_nxt = r;
    q_nxt = q;
    if (op_is_div(op)) begin
      // Remainder stays below b between iterations, so W+1 bits are enough
      // once the (possible) subtraction is done.
      r_nxt = sub_ok ? (WIDTH+1)'(rq_sh - {2'b00, b}) : rq_sh[WIDTH:0];
      q_nxt = {q[WIDTH-2:0], sub_ok};
    end else begin
      p_nxt = {mul_sum, p[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU for the execute stage.
// Latency: WIDTH+1 cycles from start to the one-cycle valid; 1 cycle for divide by zero.
// Backpressure: stall holds FD/DX while busy; flush aborts without a result.
// Ports: clk/n_reset (async active-low), flush_i, start_i, op_i, rs_val_i (A),
// rd_val_i (B) in; stall_o (combinational from start/flush), valid_o and
// result_o (zero unless valid) out.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = kMULDIV_W
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             flush_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_val_i,
  input  logic [WIDTH-1:0] rd_val_i,
  output logic             stall_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

  muldiv_state_e      state;
  logic [CW-1:0]      cnt;
  muldiv_op_e         op_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] p_q;
  logic [WIDTH:0]     r_q;
  logic [WIDTH-1:0]   q_q;
  logic [WIDTH-1:0]   res_q;

  logic [2*WIDTH-1:0] p_nxt;
  logic [WIDTH:0]     r_nxt;
  logic [WIDTH-1:0]   q_nxt;

  muldiv_op_e op_in;
  assign op_in = muldiv_op_e'(op_i);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op    (op_q),
    .p     (p_q),
    .r     (r_q),
    .q     (q_q),
    .b     (b_q),
    .p_nxt (p_nxt),
    .r_nxt (r_nxt),
    .q_nxt (q_nxt)
  );

  function automatic logic [WIDTH-1:0] sel_result(
    input muldiv_op_e         op,
    input logic [2*WIDTH-1:0] p,
    input logic [WIDTH-1:0]   r,
    input logic [WIDTH-1:0]   q
  );
    case (op)
      OP_MUL:   return p[WIDTH-1:0];
      OP_MULHU: return p[2*WIDTH-1:WIDTH];
      OP_DIVU:  return q;
      default:  return r;
    endcase
  endfunction

  // The result is captured on the transition into DONE so the outputs only
  // ever come from registers, never from the operand inputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= OP_MUL;
      b_q   <= '0;
      p_q   <= '0;
      r_q   <= '0;
      q_q   <= '0;
      res_q <= '0;
    end else if (flush_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            op_q <= op_in;
            b_q  <= rd_val_i;
            p_q  <= {{WIDTH{1'b0}}, rs_val_i};
            r_q  <= '0;
            q_q  <= rs_val_i;
            if (op_is_div(op_in) && (rd_val_i == '0)) begin
              // Divide by zero skips iteration entirely.
              res_q <= (op_in == OP_DIVU) ? '1 : rs_val_i;
              state <= DONE;
            end else begin
              cnt   <= CNT_LOAD;
              state <= RUN;
            end
          end
        end
        RUN: begin
          p_q <= p_nxt;
          r_q <= r_nxt;
          q_q <= q_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            res_q <= sel_result(op_q, p_nxt, r_nxt[WIDTH-1:0], q_nxt);
            state <= DONE;
          end
        end
        DONE: begin
          // DX advances at this edge; the instruction still on start_i is
          // the one just completed.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign valid_o  = (state == DONE) & ~flush_i;
  assign result_o = valid_o ? res_q : '0;
  // Gated by reset so the pipeline never sees a stall while held in reset.
  assign stall_o  = n_reset & ~flush_i &
                    (((state == IDLE) & start_i) | (state == RUN));

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          flush_i;
  logic          start_i;
  logic [1:0]    op_i;
  logic [W-1:0]  rs_val_i;
  logic [W-1:0]  rd_val_i;
  logic          stall_o;
  logic          valid_o;
  logic [W-1:0]  result_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .flush_i  (flush_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs_val_i (rs_val_i),
    .rd_val_i (rd_val_i),
    .stall_o  (stall_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got stall/valid/result=%h, expected %h", name, act, exp);
  endtask

  function automatic logic [W+1:0] obs();
    return {stall_o, valid_o, result_o};
  endfunction

  // Reference: plain arithmetic on the architectural definition.
  function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      2'd0:    return prod[W-1:0];
      2'd1:    return prod[2*W-1:W];
      2'd2:    return (b == 0) ? {W{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [W-1:0] b);
    return (op[1] && b == 0) ? 1 : LAT;
  endfunction

  // Entered shortly after a rising edge. Holds start_i like DX would until
  // the DONE cycle, then either drops it and checks the idle cycle, or
  // returns at the edge so the caller can chain the next instruction.
  task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input int lat,
                        input bit chain);
    logic [W+1:0] expv;
    start_i  = 1'b1;
    op_i     = op;
    rs_val_i = a;
    rd_val_i = b;
    #1;
    for (int c = 0; c <= lat; c++) begin
      expv = (c < lat) ? {1'b1, 1'b0, {W{1'b0}}} : {1'b0, 1'b1, exp};
      chk($sformatf("%s t%0d", name, c), obs(), expv);
      @(posedge clk); #1;
    end
    if (!chain) begin
      start_i  = 1'b0;
      rs_val_i = $urandom;
      rd_val_i = $urandom;
      #1;
      chk($sformatf("%s idle", name), obs(), '0);
    end
  endtask

  task automatic add_vec(input string n, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
    vecs.push_back(v);
  endtask

  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;

    add_vec("mul_7x6",      2'd0, 32'd7,          32'd6,          32'd42,         LAT);
    add_vec("mulhu_max",    2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  LAT);
    add_vec("mul_max",      2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  LAT);
    add_vec("divu_100_7",   2'd2, 32'd100,        32'd7,          32'd14,         LAT);
    add_vec("remu_100_7",   2'd3, 32'd100,        32'd7,          32'd2,          LAT);
    add_vec("divu_max_1",   2'd2, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  LAT);
    add_vec("divu_5_0",     2'd2, 32'd5,          32'd0,          32'hFFFF_FFFF,  1);
    add_vec("remu_5_0",     2'd3, 32'd5,          32'd0,          32'd5,          1);
    add_vec("remu_big_max", 2'd3, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  LAT);
    add_vec("mulhu_2p31x2", 2'd1, 32'h8000_0000,  32'd2,          32'd1,          LAT);

    // Reset: outputs quiet even with start_i asserted.
    n_reset  = 1'b0;
    flush_i  = 1'b0;
    start_i  = 1'b1;
    op_i     = 2'd0;
    rs_val_i = 32'd3;
    rd_val_i = 32'd4;
    #12;
    chk("reset outputs", obs(), '0);
    start_i = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    @(posedge clk); #1;
    chk("idle after reset", obs(), '0);

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b0);

    // Back-to-back: second instruction seen in IDLE right after DONE.
    run_op("b2b_first",  2'd2, 32'd1000, 32'd10, 32'd100, LAT, 1'b1);
    run_op("b2b_second", 2'd0, 32'd12,   32'd12, 32'd144, LAT, 1'b0);
    run_op("b2b_div0",   2'd3, 32'd77,   32'd0,  32'd77,  1,   1'b1);
    run_op("b2b_after0", 2'd3, 32'd77,   32'd10, 32'd7,   LAT, 1'b0);

    // Flush at t10 of a MUL, then a fresh MUL 3x3 at t12.
    start_i = 1'b1; op_i = 2'd0; rs_val_i = 32'd1234; rd_val_i = 32'd5678;
    #1;
    chk("flush_seq t0", obs(), {1'b1, 1'b0, {W{1'b0}}});
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
    end
    flush_i = 1'b1;
    #1;
    chk("flush_seq t10", obs(), '0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    start_i = 1'b0;
    #1;
    chk("flush_seq t11", obs(), '0);
    @(posedge clk); #1;
    run_op("after_flush_3x3", 2'd0, 32'd3, 32'd3, 32'd9, LAT, 1'b0);

    // Asynchronous reset at t15 of a DIVU.
    start_i = 1'b1; op_i = 2'd2; rs_val_i = 32'd1000; rd_val_i = 32'd3;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
    end
    n_reset = 1'b0;
    #1;
    chk("async reset mid run", obs(), '0);
    @(posedge clk); #1;
    chk("held in reset", obs(), '0);
    start_i = 1'b0;
    n_reset = 1'b1;
    #1;
    chk("released reset", obs(), '0);
    @(posedge clk); #1;
    start_i = 1'b1; flush_i = 1'b1; op_i = 2'd0; rs_val_i = 32'd9; rd_val_i = 32'd9;
    #1;
    chk("start with flush", obs(), '0);
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    chk("no start after flush", obs(), '0);
    @(posedge clk); #1;
    run_op("post_reset_divu", 2'd2, 32'd1000, 32'd3, 32'd333, LAT, 1'b0);

    // Randomised operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1, 2:    rb = $urandom_range(1, 255);
        3:       rb = ra >> $urandom_range(0, 8);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, ref_result(rop, ra, rb),
             ref_lat(rop, rb), 1'($urandom_range(0, 1)));
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    chk("final idle", obs(), '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative unsigned multiply/divide unit in the execute stage. It consumes operands and the decoded multiply/divide operation from the DX pipeline register outputs. It holds the front of the pipeline via `stall_o` while it iterates, and presents a one-cycle-valid result to the execute-stage result mux. Radix-2: one bit per cycle for both multiply (shift-add) and divide (restoring).

## Interface
Parameters:
- `WIDTH`, 32, operand/result width in bits; iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `n_reset`  in  1  asynchronous, active-low reset.
- `flush_i`  in  1  branch/exception flush; aborts any operation.
- `start_i`  in  1  DX holds a valid multiply/divide instruction (decoder qualified).
- `op_i`  in  2  `muldiv_op_e`: 00 MUL (low half), 01 MULHU (high half), 10 DIVU (quotient), 11 REMU (remainder).
- `rs_val_i`  in  WIDTH  operand A (multiplicand/dividend).
- `rd_val_i`  in  WIDTH  operand B (multiplier/divisor).
- `stall_o`  out  1  hold FD and DX registers.
- `valid_o`  out  1  `result_o` valid this cycle.
- `result_o`  out  WIDTH  result.

## Operation
- FSM states are `IDLE`, `RUN`, `DONE`. Reset puts the FSM in `IDLE`, counter 0, all data registers 0. `stall_o`, `valid_o` and `result_o` are 0 during reset.
- `IDLE`:
  - `start_i & !flush_i` latches A, B and op.
  - If op is DIVU/REMU and B==0, go to `DONE`. The result is 0xFFFF_FFFF for DIVU and A for REMU.
  - Otherwise load counter = `WIDTH` and go to `RUN`.
- `RUN` (multiply): product register P is 2*WIDTH bits, initialised {0, A}. Each cycle, if P[0], P[2W-1:W] += B with carry into a W+1-bit sum. Then P = {carry, sum, P[W-1:1]} shifted right by 1.
- `RUN` (divide): remainder R is W+1 bits, quotient Q initialised to A. Each cycle:
  - Shift {R,Q} left by 1.
  - Compute T = R − B.
  - If T is non-negative, R = T and Q[0] = 1; otherwise Q[0] = 0.
- Counter decrements every `RUN` cycle. When it reaches 1 in `RUN`, the next state is `DONE`.
- `DONE`:
  - `valid_o = 1`.
  - `result_o` is P[W-1:0] (MUL), P[2W-1:W] (MULHU), Q (DIVU) or R[W-1:0] (REMU).
  - Next state is `IDLE` unconditionally. `start_i` is ignored in `DONE`, because DX still holds the same instruction this cycle and advances at this edge.
- `stall_o = !flush_i & ((state==IDLE & start_i) | state==RUN)`. It is combinational, so DX holds on the same cycle `start_i` first appears.
- `result_o` is 0 whenever `valid_o` is 0.
- Flush in any state: next state `IDLE`, counter cleared, `valid_o` and `stall_o` low in the flush cycle. No result is produced for the aborted instruction.
- Flush coincident with `start_i` in `IDLE`: the operation does not start.
- `n_reset` asserted mid-`RUN`: immediate return to reset values. No result is produced.

## Timing
- Start cycle is t0 (`IDLE`, `start_i`=1).
- Normal operation:
  - `RUN` occupies t1..tW.
  - `DONE` is at tW+1, with `valid_o`=1 and `stall_o`=0.
  - Total stall is W+1 cycles: t0..tW.
- Divide by zero: `DONE` at t1, stall during t0 only.
- Back-to-back muldiv instructions: the second is seen in `IDLE` at tW+2 at the earliest.
- `valid_o` is high for exactly one cycle per completed operation.
- No combinational path from operand inputs to outputs. Only `flush_i` and `start_i` reach `stall_o` combinationally.

## Structure
- Add to `definitions.sv`:
  - `muldiv_op_e` (2-bit enum).
  - `muldiv_state_e` (`IDLE`/`RUN`/`DONE`).
  - `kMULDIV_W` = 32.
- Sub-module `muldiv_step`: purely combinational single-iteration datapath.
  - Inputs: op, P, R, Q, B.
  - Outputs: next P/R/Q.
- The top holds the FSM, counter, registers and output mux.

## Test plan
- MUL 7×6: `start_i` at t0 → `stall_o` high t0..t32, `valid_o`=1 at t33 with `result_o`=42, then `stall_o`=0.
- MULHU 0xFFFF_FFFF×0xFFFF_FFFF → `result_o`=0xFFFF_FFFE at t33; MUL with the same operands → 0x0000_0001.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 0xFFFF_FFFF/1 → 0xFFFF_FFFF; all at t33.
- DIVU 5/0 → 0xFFFF_FFFF at t1; REMU 5/0 → 5 at t1; `stall_o` high at t0 only.
- `flush_i` at t10 of a MUL:
  - `stall_o` low at t10.
  - No `valid_o` at any later cycle.
  - A new MUL 3×3 at t12 → 9 at t45.
- `n_reset` low at t15 of a DIVU → all outputs 0 immediately and FSM in `IDLE`. After release, `start_i` with `flush_i` asserted in the same cycle → no stall, no start.
